// File: rtl/freq_meter.sv
// Counts sig_in rising edges over a gated window of MAIN_CLOCK/10^range cycles.
// Latency: result is valid in the DONE cycle right after a G-cycle window; sig_in edges take 3 cycles to register.
// No backpressure: valid is a one-cycle pulse, and results hold until the next completed window.
module freq_meter #(
    parameter int unsigned MAIN_CLOCK = 50_000_000
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        sig_in,
    input  logic        en,
    input  logic [1:0]  range,
    output logic [31:0] freq_count,
    output logic [1:0]  scale,
    output logic        valid,
    output logic        busy,
    output logic        no_signal
);

    localparam logic [31:0] GATE_LAST_0 = 32'(MAIN_CLOCK - 1);
    localparam logic [31:0] GATE_LAST_1 = 32'(MAIN_CLOCK / 10 - 1);
    localparam logic [31:0] GATE_LAST_2 = 32'(MAIN_CLOCK / 100 - 1);
    localparam logic [31:0] GATE_LAST_3 = 32'(MAIN_CLOCK / 1000 - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        sync1;
    logic        sync2;
    logic        sync_prev;
    logic        sig_edge;

    logic [31:0] gate_cnt;
    logic [31:0] edge_cnt;
    logic [31:0] edge_total;
    logic [31:0] gate_last;
    logic [1:0]  win_range;
    logic        start_win;
    logic        end_win;

    // Two-flop synchronizer plus one history flop for rising-edge detection
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync1     <= sig_in;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    assign sig_edge = sync2 & ~sync_prev;

    always_comb begin
        case (win_range)
            2'b00:   gate_last = GATE_LAST_0;
            2'b01:   gate_last = GATE_LAST_1;
            2'b10:   gate_last = GATE_LAST_2;
            default: gate_last = GATE_LAST_3;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Dropping en aborts a window before it can complete, even on its last cycle
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        valid     = 1'b0;
        start_win = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = MEASURE;
                    start_win = 1'b1;
                end
            end
            MEASURE: begin
                busy = 1'b1;
                if (!en) begin
                    state_nxt = IDLE;
                end else if (gate_cnt == gate_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                valid = 1'b1;
                if (en) begin
                    state_nxt = MEASURE;
                    start_win = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign end_win    = (state == MEASURE) && (state_nxt == DONE);
    assign edge_total = edge_cnt + 32'(sig_edge);

    // Counters restart on every window start; edges outside MEASURE are dropped
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            gate_cnt  <= 32'd0;
            edge_cnt  <= 32'd0;
            win_range <= 2'b00;
        end else if (start_win) begin
            gate_cnt  <= 32'd0;
            edge_cnt  <= 32'd0;
            win_range <= range;
        end else if (state == MEASURE) begin
            gate_cnt  <= gate_cnt + 32'd1;
            edge_cnt  <= edge_total;
        end
    end

    // Results include the edge seen on the final gate cycle and are visible during DONE
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            freq_count <= 32'd0;
            scale      <= 2'b00;
            no_signal  <= 1'b1;
        end else if (end_win) begin
            freq_count <= edge_total;
            scale      <= win_range;
            no_signal  <= (edge_total == 32'd0);
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter with MAIN_CLOCK=10_000 (G = 10000/1000/100/10).
module tb_freq_meter;

    typedef struct packed {
        logic [31:0] cnt;
        logic [1:0]  scl;
        logic        ns;
    } exp_t;

    logic        clk_in = 1'b0;
    logic        rst    = 1'b0;
    logic        sig_in = 1'b0;
    logic        en     = 1'b0;
    logic [1:0]  range  = 2'b00;
    logic [31:0] freq_count;
    logic [1:0]  scale;
    logic        valid;
    logic        busy;
    logic        no_signal;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks  = 0;
    int   errors  = 0;
    int   n_valid = 0;
    int   mode    = 0;
    int   ph      = 0;
    bit   prev_valid = 1'b0;

    freq_meter #(.MAIN_CLOCK(10_000)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .sig_in     (sig_in),
        .en         (en),
        .range      (range),
        .freq_count (freq_count),
        .scale      (scale),
        .valid      (valid),
        .busy       (busy),
        .no_signal  (no_signal)
    );

    always #5 clk_in = ~clk_in;

    // mode 0: low, 1: period-5 square (2 high / 3 low), 2: toggle every cycle
    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            ph = (ph + 1) % 5;
            case (mode)
                1:       sig_in = (ph < 2);
                2:       sig_in = ~sig_in;
                default: sig_in = 1'b0;
            endcase
        end
    end

    // Scoreboard monitor: every valid pulse pops one expected window result
    initial begin
        forever begin
            @(negedge clk_in);
            if (valid) begin
                n_valid++;
                checks++;
                if (prev_valid) begin
                    errors++;
                    $display("FAIL valid_consecutive: valid high two cycles in a row, required single pulse");
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: got count=%0d scale=%0d, required no pulse", freq_count, scale);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({freq_count, scale, no_signal} !== {mon_e.cnt, mon_e.scl, mon_e.ns}) begin
                        errors++;
                        $display("FAIL window_result: got count=%0d scale=%0d no_signal=%0d, required count=%0d scale=%0d no_signal=%0d",
                                 freq_count, scale, no_signal, mon_e.cnt, mon_e.scl, mon_e.ns);
                    end
                end
            end
            prev_valid = valid;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_valid(input int budget, output int waited);
        waited = 0;
        do begin
            @(negedge clk_in);
            waited++;
        end while (!valid && waited < budget);
        if (!valid) waited = -1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic push(input int cnt, input logic [1:0] scl, input logic ns, input int n);
        exp_t e;
        e.cnt = 32'(cnt);
        e.scl = scl;
        e.ns  = ns;
        repeat (n) exp_q.push_back(e);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick(3);
        checks++; if (freq_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d, required 0", freq_count); end
        checks++; if (scale !== 2'b00) begin errors++; $display("FAIL reset_scale: got %0d, required 0", scale); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        checks++; if (no_signal !== 1'b1) begin errors++; $display("FAIL reset_no_signal: got %b, required 1", no_signal); end
        rst = 1'b1;
        tick(2);
    endtask

    // Runs n back-to-back windows and checks the spacing between valid pulses
    task automatic run_windows(input string name, input int n, input int first_budget, input int period);
        int w;
        wait_valid(first_budget, w);
        checks++;
        if (w < 0) begin errors++; $display("FAIL %s_first_valid: no valid within %0d cycles", name, first_budget); end
        for (int i = 1; i < n; i++) begin
            wait_valid(period + 5, w);
            checks++;
            if (w != period) begin errors++; $display("FAIL %s_interval: got %0d cycles, required %0d", name, w, period); end
        end
        tick(1);
        en = 1'b0;
        tick(3);
    endtask

    task automatic test_range10_square;
        mode = 1; range = 2'b10;
        tick(10);
        push(20, 2'b10, 1'b0, 3);
        en = 1'b1;
        run_windows("r10_square", 3, 300, 101);
    endtask

    task automatic test_range11_low;
        mode = 0; range = 2'b11;
        tick(10);
        push(0, 2'b11, 1'b1, 3);
        en = 1'b1;
        run_windows("r11_low", 3, 50, 11);
    endtask

    task automatic test_range01_toggle;
        mode = 2; range = 2'b01;
        tick(10);
        push(500, 2'b01, 1'b0, 2);
        en = 1'b1;
        run_windows("r01_toggle", 2, 1100, 1001);
    endtask

    task automatic test_range_switch;
        mode = 1; range = 2'b10;
        tick(10);
        push(20, 2'b10, 1'b0, 1);
        push(2, 2'b11, 1'b0, 1);
        en = 1'b1;
        tick(30);
        range = 2'b11;
        run_windows("range_switch", 2, 200, 11);
    endtask

    task automatic test_abort;
        int w;
        int v0;
        mode = 1; range = 2'b10;
        tick(5);
        v0 = n_valid;
        en = 1'b1;
        w = 0;
        do begin @(negedge clk_in); w++; end while (!busy && w < 10);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_start: got %b, required 1", busy); end
        tick(49);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_mid: got %b, required 1", busy); end
        en = 1'b0;
        tick(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy_after: got %b, required 0", busy); end
        checks++; if (freq_count !== 32'd2) begin errors++; $display("FAIL abort_count_held: got %0d, required 2", freq_count); end
        checks++; if (scale !== 2'b11) begin errors++; $display("FAIL abort_scale_held: got %0d, required 3", scale); end
        checks++; if (no_signal !== 1'b0) begin errors++; $display("FAIL abort_no_signal_held: got %b, required 0", no_signal); end
        tick(150);
        checks++; if (n_valid != v0) begin errors++; $display("FAIL abort_no_valid: got %0d pulses, required 0", n_valid - v0); end
    endtask

    task automatic test_reset_mid;
        int w;
        mode = 1; range = 2'b10;
        tick(10);
        push(20, 2'b10, 1'b0, 1);
        en = 1'b1;
        wait_valid(300, w);
        checks++; if (w < 0) begin errors++; $display("FAIL rstmid_first_valid: no valid within 300 cycles"); end
        mode = 0;
        tick(20);
        rst = 1'b0;
        tick(1);
        checks++; if (freq_count !== 32'd0) begin errors++; $display("FAIL rstmid_count: got %0d, required 0", freq_count); end
        checks++; if (scale !== 2'b00) begin errors++; $display("FAIL rstmid_scale: got %0d, required 0", scale); end
        checks++; if (no_signal !== 1'b1) begin errors++; $display("FAIL rstmid_no_signal: got %b, required 1", no_signal); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
        rst = 1'b1;
        push(0, 2'b10, 1'b1, 1);
        wait_valid(200, w);
        checks++; if (w != 102) begin errors++; $display("FAIL rstmid_latency: got %0d cycles, required 102", w); end
        tick(1);
        en = 1'b0;
        tick(3);
    endtask

    initial begin
        test_reset();
        test_range10_square();
        test_range11_low();
        test_range01_toggle();
        test_range_switch();
        test_abort();
        test_reset_mid();
        tick(5);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending windows, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 Parameter MAIN_CLOCK, default 50_000_000: clk_in frequency in Hz; SHALL be a multiple of 1000 and >= 2000.
REQ-002 Port clk_in  input  1: system clock; all logic SHALL be clocked on its rising edge.
REQ-003 Port rst  input  1: reset, synchronous, active-low.
REQ-004 Port sig_in  input  1: asynchronous signal under measurement.
REQ-005 Port en  input  1: measurement enable; high = continuous back-to-back windows.
REQ-006 Port range  input  2: gate select; 00 = 1 s, 01 = 100 ms, 10 = 10 ms, 11 = 1 ms.
REQ-007 Port freq_count  output  32: rising edges counted in the last completed window.
REQ-008 Port scale  output  2: range value used for the window reported in freq_count.
REQ-009 Port valid  output  1: one-cycle pulse when freq_count/scale update.
REQ-010 Port busy  output  1: high while a window is in progress.
REQ-011 Port no_signal  output  1: high when the last completed window counted zero edges.

Function
REQ-012 sig_in SHALL pass through a 2-flop synchronizer, then a 1-flop edge detector; edge = sync high and previous sync low.
REQ-013 Gate length G in clk_in cycles SHALL be MAIN_CLOCK, MAIN_CLOCK/10, MAIN_CLOCK/100, or MAIN_CLOCK/1000 for range 00/01/10/11.
REQ-014 The FSM SHALL have three states: IDLE, MEASURE, DONE.
REQ-015 IDLE: busy=0; on a cycle with en=1, next state MEASURE. Gate counter and edge counter clear, range is sampled into a window register.
REQ-016 MEASURE: busy=1; the gate counter increments each cycle from 0. Each cycle with edge=1 increments the edge counter.
REQ-017 When the gate counter equals G-1, counting SHALL include that cycle's edge, and the next state SHALL be DONE. A window is exactly G cycles.
REQ-018 DONE (1 cycle): freq_count takes the edge counter and scale takes the window range. no_signal = (count==0). valid=1 for this cycle only.
REQ-019 From DONE: if en=1, go to MEASURE with counters cleared and range re-sampled, with no gap cycle other than DONE. If en=0, go to IDLE.
REQ-020 A range change during MEASURE SHALL be ignored until the next window starts.
REQ-021 en falling during MEASURE SHALL abort to IDLE on the next cycle. There is no valid pulse, and freq_count/scale/no_signal keep their previous values.
REQ-022 An edge in the DONE cycle SHALL NOT be counted in either window.
REQ-023 Edge counter width SHALL be 32 bits. No overflow is possible, since edges <= G/2 < 2^31.
REQ-024 Outputs SHALL hold between valid pulses. valid SHALL never assert twice in consecutive cycles.
REQ-025 Detection latency is 3 cycles from a sig_in rise to its edge pulse. Edges within 3 cycles of window start/end SHALL be attributed by edge-pulse cycle.

Reset
REQ-026 When rst=0 at a clock edge, the FSM SHALL go to IDLE, and all counters and synchronizer flops SHALL go to 0.
REQ-027 Reset values: freq_count=0, scale=00, valid=0, busy=0, no_signal=1.
REQ-028 Reset mid-window SHALL discard the window, with no valid pulse. Measurement resumes only after rst=1 and en=1.

Verification (MAIN_CLOCK=10_000 for bench: G = 10000/1000/100/10)
REQ-029 range=10, en=1, sig_in square period 5 cycles -> every valid shows freq_count=20, scale=10, no_signal=0. valid pulses are 101 cycles apart.
REQ-030 range=11, sig_in held low -> freq_count=0, no_signal=1, valid every 11 cycles.
REQ-031 range=01, sig_in period 2 cycles (toggle every clk) -> freq_count=500 each window.
REQ-032 range switched 10->11 mid-window -> current window reports scale=10 with G=100. The next window reports scale=11 with G=10.
REQ-033 en dropped 50 cycles into a range=10 window -> no valid, busy=0 next cycle, freq_count unchanged.
REQ-034 rst=0 for 1 cycle mid-window after one valid window -> freq_count=0, scale=00, no_signal=1, busy=0. With en=1, the first valid occurs 1+G+1 cycles after rst returns high.
